// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    DONE
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic int unsigned index_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned addr_width, input int unsigned sets);
    return addr_width - $clog2(sets) - 2;
  endfunction

endpackage

// File: rtl/dcache_align.sv
// Load byte/half selection with sign/zero extension, and store byte-lane merge.
module dcache_align
  import dcache_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] line,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = line[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? line[31:16] : line[15:0];

    unique case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'b0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'b0, half_sel};
      default: load_data = line;
    endcase
  end

  always_comb begin
    store_data = line;
    unique case (funct3)
      F3_B: store_data[{offset, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (offset[1]) store_data[31:16] = wdata[15:0];
        else           store_data[15:0]  = wdata[15:0];
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache with miss FSM.
// Optional hit/miss statistics counters enabled by DCACHE_STATS_EN.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned SETS       = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [2:0]            cpu_funct3,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int unsigned IW = index_bits(SETS);
  localparam int unsigned TW = tag_bits(ADDR_WIDTH, SETS);

  logic [IW-1:0]         index, miss_index;
  logic [TW-1:0]         tag, miss_tag;
  logic [SETS-1:0]       valid, dirty;
  logic [TW-1:0]         tags [SETS];
  logic [DATA_WIDTH-1:0] data [SETS];
  state_t                state;
  logic                  hit, miss, serve, ack;
  logic [31:0]           line, store_data;

  assign index = cpu_addr[IW+1:2];
  assign tag   = cpu_addr[ADDR_WIDTH-1:IW+2];
  assign line  = data[index];
  assign hit   = valid[index] && (tags[index] == tag);
  assign miss  = (state == IDLE) && cpu_req && !hit;
  // The DONE cycle completes the stalled access exactly like a hit.
  assign serve = cpu_req && (((state == IDLE) && hit) || (state == DONE));
  assign ack   = mem_ack && mem_req;
  assign stall = !rst && (miss || (state == WRITEBACK) || (state == REFILL));

  dcache_align u_align (
    .funct3     (cpu_funct3),
    .offset     (cpu_addr[1:0]),
    .line       (line),
    .wdata      (cpu_wdata),
    .load_data  (cpu_rdata),
    .store_data (store_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      if ((state == REFILL) && ack) begin
        data[miss_index] <= mem_rdata;
        tags[miss_index] <= miss_tag;
      end else if (serve && cpu_we) begin
        data[index] <= store_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      miss_index <= '0;
      miss_tag   <= '0;
    end else begin
      if (serve && cpu_we) dirty[index] <= 1'b1;
      unique case (state)
        IDLE: begin
          if (miss) begin
            miss_index <= index;
            miss_tag   <= tag;
            mem_req    <= 1'b1;
            if (valid[index] && dirty[index]) begin
              state     <= WRITEBACK;
              mem_we    <= 1'b1;
              mem_addr  <= {tags[index], index, 2'b00};
              mem_wdata <= line;
            end else begin
              state    <= REFILL;
              mem_we   <= 1'b0;
              mem_addr <= {tag, index, 2'b00};
            end
          end
        end
        WRITEBACK: begin
          if (ack) begin
            state    <= REFILL;
            mem_we   <= 1'b0;
            mem_addr <= {miss_tag, miss_index, 2'b00};
          end
        end
        REFILL: begin
          if (ack) begin
            state             <= DONE;
            mem_req           <= 1'b0;
            valid[miss_index] <= 1'b1;
            dirty[miss_index] <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hits, misses;

  always_ff @(posedge clk) begin
    if (rst) begin
      hits   <= '0;
      misses <= '0;
    end else begin
      if ((state == IDLE) && cpu_req && hit) hits <= hits + 32'd1;
      if (miss) misses <= misses + 32'd1;
    end
  end

  assign hit_count  = hits;
  assign miss_count = misses;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized accesses
// against an array-based cache/backing-memory model.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  localparam int unsigned SETS = 64;

  logic        clk = 1'b0;
  logic        rst, cpu_req, cpu_we, stall, mem_req, mem_we, mem_ack;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  dcache_ctrl #(.SETS(SETS), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  int unsigned checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: cache lines and a flat backing memory keyed by word address.
  bit          mv [SETS];
  bit          md [SETS];
  logic [31:0] mt [SETS];
  logic [31:0] mdat [SETS];
  logic [31:0] bk [int unsigned];
  int unsigned exp_hits = 0, exp_misses = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!bk.exists(a)) bk[a] = $urandom;
    return bk[a];
  endfunction

  function automatic void reset_model();
    for (int i = 0; i < SETS; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] b = (w >> (8 * off)) & 32'hFF;
    logic [31:0] h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [2:0] f3,
                                        input logic [1:0] off, input logic [31:0] d);
    logic [31:0] m;
    int unsigned sh;
    case (f3)
      3'b000:  begin sh = 8 * off;     m = 32'hFF << sh;   end
      3'b001:  begin sh = 16 * off[1]; m = 32'hFFFF << sh; end
      default: begin sh = 0;           m = '1;             end
    endcase
    return (w & ~m) | ((d << sh) & m);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic mem_txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input int unsigned lat, inout int unsigned stalls);
    for (int unsigned i = 0; i < lat; i++) begin
      next_cycle();
      if (i == lat - 1) begin
        mem_ack   = 1'b1;
        mem_rdata = we ? $urandom : mem_word(a);
      end
      @(negedge clk);
      if (stall) stalls++;
      check("mem_req", 32'(mem_req), 32'd1);
      check("mem_we", 32'(mem_we), 32'(we));
      check("mem_addr", mem_addr, a);
      if (we) check("mem_wdata", mem_wdata, wd);
    end
  endtask

  task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int unsigned wb_lat,
                        input int unsigned rf_lat, output logic [31:0] rd);
    int unsigned idx    = (a >> 2) % SETS;
    logic [31:0] tg     = a / (4 * SETS);
    logic [31:0] la     = a & ~32'h3;
    bit          is_hit = mv[idx] && (mt[idx] == tg);
    int unsigned stalls = 0;
    logic [31:0] victim;
    next_cycle();
    cpu_req    = 1'b1;
    cpu_we     = we;
    cpu_funct3 = f3;
    cpu_addr   = a;
    cpu_wdata  = wd;
    mem_ack    = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (is_hit) begin
      exp_hits++;
      check("hit_stall", 32'(stall), 32'd0);
      check("hit_mem_req", 32'(mem_req), 32'd0);
      rd = cpu_rdata;
      if (!we) check("load_hit_data", cpu_rdata, fmt_load(mdat[idx], f3, a[1:0]));
      else begin
        mdat[idx] = merge(mdat[idx], f3, a[1:0], wd);
        md[idx]   = 1'b1;
      end
    end else begin
      exp_misses++;
      if (stall) stalls++;
      if (mv[idx] && md[idx]) begin
        victim = mt[idx] * (4 * SETS) + idx * 4;
        mem_txn(1'b1, victim, mdat[idx], wb_lat, stalls);
        bk[victim] = mdat[idx];
      end else begin
        wb_lat = 0;
      end
      mem_txn(1'b0, la, 32'd0, rf_lat, stalls);
      mv[idx]   = 1'b1;
      md[idx]   = 1'b0;
      mt[idx]   = tg;
      mdat[idx] = mem_word(la);
      next_cycle();
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("done_stall", 32'(stall), 32'd0);
      check("done_mem_req", 32'(mem_req), 32'd0);
      rd = cpu_rdata;
      if (!we) check("load_miss_data", cpu_rdata, fmt_load(mdat[idx], f3, a[1:0]));
      else begin
        mdat[idx] = merge(mdat[idx], f3, a[1:0], wd);
        md[idx]   = 1'b1;
      end
      check("stall_cycles", stalls, 1 + wb_lat + rf_lat);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef DCACHE_STATS_EN
    check({tag, "_hits"}, hit_count, exp_hits);
    check({tag, "_misses"}, miss_count, exp_misses);
`else
    check({tag, "_hits"}, hit_count, 32'd0);
    check({tag, "_misses"}, miss_count, 32'd0);
`endif
  endtask

  logic [31:0] rd;
  logic [2:0]  load_f3 [8];
  logic [2:0]  f3;

  initial begin
    load_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_funct3 = '0;
    cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check_stats("rst");

    bk[32'h100] = 32'hDEADBEEF;
    access(1'b0, F3_W, 32'h100, 32'd0, 0, 3, rd);
    check("cold_load", rd, 32'hDEADBEEF);
    access(1'b0, F3_W, 32'h100, 32'd0, 0, 1, rd);
    check("repeat_load", rd, 32'hDEADBEEF);

    access(1'b1, F3_W, 32'h100, 32'h80FF7F01, 0, 1, rd);
    access(1'b0, F3_B, 32'h101, 32'd0, 0, 1, rd);
    check("lb_101", rd, 32'h0000007F);
    access(1'b0, F3_BU, 32'h103, 32'd0, 0, 1, rd);
    check("lbu_103", rd, 32'h00000080);
    access(1'b0, F3_B, 32'h103, 32'd0, 0, 1, rd);
    check("lb_103", rd, 32'hFFFFFF80);
    access(1'b0, F3_H, 32'h102, 32'd0, 0, 1, rd);
    check("lh_102", rd, 32'hFFFF80FF);

    access(1'b1, F3_W, 32'h000, 32'h12345678, 2, 2, rd);
    access(1'b0, F3_W, 32'h100, 32'd0, 3, 2, rd);
    check("evict_writeback_data", bk[32'h000], 32'h12345678);

    access(1'b1, F3_W, 32'h000, 32'h11223344, 1, 2, rd);
    access(1'b1, F3_B, 32'h002, 32'h000000AB, 1, 1, rd);
    access(1'b0, F3_W, 32'h000, 32'd0, 1, 1, rd);
    check("sb_merge", rd, 32'h11AB3344);

    // Abandon a refill with reset; a late ack must be ignored.
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = F3_W; cpu_addr = 32'h314;
    @(negedge clk);
    check("rstmiss_stall", 32'(stall), 32'd1);
    next_cycle();
    @(negedge clk);
    check("rstmiss_req", 32'(mem_req), 32'd1);
    check("rstmiss_addr", mem_addr, 32'h314);
    next_cycle();
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    next_cycle();
    rst = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    check("rstmiss_req_after", 32'(mem_req), 32'd0);
    check("rstmiss_stall_after", 32'(stall), 32'd0);
    reset_model();
    next_cycle();
    @(negedge clk);
    check("rstmiss_idle_req", 32'(mem_req), 32'd0);

    access(1'b0, F3_W, 32'h314, 32'd0, 0, 2, rd);
    repeat (3) access(1'b0, F3_W, 32'h314, 32'd0, 0, 1, rd);
    access(1'b0, F3_W, 32'h400, 32'd0, 0, 1, rd);
`ifdef DCACHE_STATS_EN
    check("stats_hits3", hit_count, 32'd3);
    check("stats_misses2", miss_count, 32'd2);
`else
    check("stats_hits_off", hit_count, 32'd0);
    check("stats_misses_off", miss_count, 32'd0);
`endif

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      bit          we;
      a  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      we = ($urandom_range(0, 2) == 0);
      f3 = we ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 7)];
      access(we, f3, a, $urandom, $urandom_range(1, 4), $urandom_range(1, 4), rd);
      if ($urandom_range(0, 3) == 0) begin
        next_cycle();
        cpu_req = 1'b0;
        mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_mem_req", 32'(mem_req), 32'd0);
      end
    end
    check_stats("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
